pwm_demodulator: RTL



---
 rtl/sdr_pwm_pkg.sv | 16 +
 rtl/pwm_input_conditioner.sv | 57 +++++
 rtl/pwm_demodulator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sdr_pwm_pkg.sv
// Definitions shared by the SDR PWM DAC and the PWM demodulator: the receiver
// state encoding and the offset-binary convention (sample + 2^(WIDTH-1)).
package sdr_pwm_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } demod_state_t;

  // Offset added to a signed sample to get the PWM high time.
  function automatic int unsigned pwm_offset(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pwm_input_conditioner.sv
// Synchroniser and rise detector for the asynchronous PWM input.
// Defining PWM_DEMOD_GLITCH_FILTER_EN adds a registered 3-tap majority filter (+2 clocks).
module pwm_input_conditioner #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic clock_areset_n,
  input  logic pwm_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic                   s_d;

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign sync_bit = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       s_q;

  // Majority of the last three synchronised bits; a one-clock blip never wins.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      hist_q <= '0;
      s_q    <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_bit};
      s_q    <= (sync_bit & hist_q[0]) | (sync_bit & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign s = s_q;
`else
  assign s = sync_bit;
`endif

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      s_d <= 1'b0;
    end else begin
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;

endmodule

// File: rtl/pwm_demodulator.sv
// Recovers signed samples from an offset-binary PWM stream of 2^WIDTH-clock frames.
// Optional input glitch filter: define PWM_DEMOD_GLITCH_FILTER_EN.
module pwm_demodulator
  import sdr_pwm_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TOL    = 1,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                    clock,
  input  logic                    clock_areset_n,
  input  logic                    pwm_in,
  output logic                    data_valid,
  output logic signed [WIDTH-1:0] data,
  output logic                    locked,
  output logic                    sync_error
);

  localparam int CNT_W  = WIDTH + 1;
  localparam int GOOD_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((1 << WIDTH) - 1);
  localparam logic [CNT_W-1:0]  EARLY_CNT = CNT_W'((1 << WIDTH) - EDGE_TOL);
  localparam logic [CNT_W-1:0]  TOL_CNT   = CNT_W'(EDGE_TOL);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_FRAMES - 1);
  localparam logic [WIDTH-1:0]  OFFSET    = WIDTH'(pwm_offset(WIDTH));

  demod_state_t      state, state_next;
  logic [CNT_W-1:0]  frame_cnt, frame_cnt_next;
  logic [CNT_W-1:0]  high_cnt, high_cnt_next;
  logic [GOOD_W-1:0] good, good_next;

  logic s;
  logic rise;
  logic wrap;
  logic early_rise;
  logic late_rise;
  logic bad_rise;
  logic frame_end;
  logic emit;
  logic error_next;

  logic [CNT_W-1:0] frame_total;
  logic [WIDTH-1:0] sample_sat;
  logic [WIDTH-1:0] sample_value;

  pwm_input_conditioner #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond (
    .clock          (clock),
    .clock_areset_n (clock_areset_n),
    .pwm_in         (pwm_in),
    .s              (s),
    .rise           (rise)
  );

  // A rise at frame_cnt 0 is the on-time edge after a wrap; it only restarts counting.
  assign wrap       = (frame_cnt == LAST_CNT) && !rise;
  assign early_rise = rise && (frame_cnt >= EARLY_CNT);
  assign late_rise  = rise && (frame_cnt != '0) && (frame_cnt <= TOL_CNT);
  assign bad_rise   = rise && (frame_cnt != '0) && !early_rise && !late_rise;
  assign frame_end  = wrap || early_rise;

  // On a wrap the current cycle still belongs to the ending frame; on an early edge it does not.
  assign frame_total  = wrap ? (high_cnt + CNT_W'(s)) : high_cnt;
  assign sample_sat   = (frame_total > LAST_CNT) ? {WIDTH{1'b1}} : frame_total[WIDTH-1:0];
  assign sample_value = sample_sat - OFFSET;

  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    high_cnt_next  = high_cnt;
    good_next      = good;
    emit           = 1'b0;
    error_next     = 1'b0;

    case (state)
      SEARCH: begin
        if (rise) begin
          state_next     = ACQUIRE;
          frame_cnt_next = CNT_ONE;
          high_cnt_next  = CNT_ONE;
          good_next      = '0;
        end
      end

      ACQUIRE, LOCKED: begin
        frame_cnt_next = (frame_cnt == LAST_CNT) ? '0 : frame_cnt + CNT_ONE;
        high_cnt_next  = wrap ? '0 : high_cnt + CNT_W'(s);

        if (rise) begin
          frame_cnt_next = CNT_ONE;
          high_cnt_next  = CNT_ONE;
        end

        if (bad_rise) begin
          error_next = 1'b1;
          good_next  = '0;
          state_next = ACQUIRE;
        end else if (frame_end) begin
          if (state == LOCKED) begin
            emit = 1'b1;
          end else if (good == LOCK_LAST) begin
            state_next = LOCKED;
            good_next  = '0;
          end else begin
            good_next = good + GOOD_ONE;
          end
        end
      end

      default: begin
        state_next     = SEARCH;
        frame_cnt_next = '0;
        high_cnt_next  = '0;
        good_next      = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      state      <= SEARCH;
      frame_cnt  <= '0;
      high_cnt   <= '0;
      good       <= '0;
      data_valid <= 1'b0;
      data       <= '0;
      sync_error <= 1'b0;
    end else begin
      state      <= state_next;
      frame_cnt  <= frame_cnt_next;
      high_cnt   <= high_cnt_next;
      good       <= good_next;
      data_valid <= emit;
      sync_error <= error_next;
      if (emit) begin
        data <= sample_value;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule
